load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/core_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 43 ++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: access size codes, LSU state encoding
// and the default memory-acknowledge timeout.
package core_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int LSU_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  function automatic logic bad_access(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    return (size == SZ_ILL) ||
           (size == SZ_HALF && lane[0]) ||
           (size == SZ_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane extraction for loads and lane merge for
// read-modify-write stores; purely combinational.
module lsu_lane_align
  import core_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    ld_data = rdata;
    st_word = wdata;
    unique case (1'b1)
      size == SZ_BYTE: begin
        ld_data = uns ? {24'b0, b} : {{24{b[7]}}, b};
        st_word = rdata;
        st_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      size == SZ_HALF: begin
        ld_data = uns ? {16'b0, h} : {{16{h[15]}}, h};
        st_word = rdata;
        st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        ld_data = rdata;
        st_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time, sub-word stores done as
// read-modify-write, bounded wait on mem_ack.
module load_store_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic [31:0] ld_data, st_word;
  logic [1:0]  size_q;
  logic        uns_q, we_q, err_q;
  logic        accept, bad, busy, expired;

  assign accept  = req_valid && state == ST_IDLE;
  assign bad     = bad_access(req_size, req_addr[1:0]);
  assign busy    = state == ST_READ || state == ST_WRITE;
  assign expired = busy && !mem_ack &&
                   cnt == CW'(TIMEOUT_CYCLES - 1);

  assign req_ready  = state == ST_IDLE;
  assign resp_valid = state == ST_RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q) ? rdata_q : '0;
  assign mem_rd_en  = state == ST_READ;
  assign mem_wr_en  = state == ST_WRITE;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = word_q;

  lsu_lane_align u_align (
    .lane    (addr_q[1:0]),
    .size    (size_q),
    .uns     (uns_q),
    .rdata   (mem_rdata),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (req_valid) begin
          if (bad)                   state_n = ST_RESP;
          else if (!req_we)          state_n = ST_READ;
          else if (req_size == SZ_WORD) state_n = ST_WRITE;
          else                       state_n = ST_READ;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          state_n = we_q ? ST_WRITE : ST_RESP;
          cnt_n   = '0;
        end else if (expired) begin
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_WRITE: begin
        if (mem_ack || expired) state_n = ST_RESP;
        else                    cnt_n   = cnt + 1'b1;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        word_q  <= req_wdata;
        rdata_q <= '0;
        err_q   <= bad;
      end else if (state == ST_READ && mem_ack) begin
        // a store reaching READ is a sub-word RMW: keep the merged word
        if (we_q) word_q  <= st_word;
        else      rdata_q <= ld_data;
      end else if (expired) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model
// predicts each response and memory traffic, checked every cycle.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd_en, mem_wr_en, mem_ack;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit [31:0] mem [1024];

  // expectations written by the driver, read by the compare process
  bit        exp_active = 0;
  logic [31:0] exp_rdata, exp_wdata, exp_maddr;
  logic      exp_err;
  int        exp_rd, exp_wr, exp_strobe, exp_lat;
  int        ack_delay = 0;
  bit        stray_ack = 0;
  int        resp_base;

  // state owned by the compare process
  int        cyc = 0, acc_cyc = 0, wait_cnt = 0;
  int        n_rd = 0, n_wr = 0, n_strobe = 0, resp_seen = 0;
  logic [1:0] kind, prev_kind = 2'b00;
  logic [31:0] last_rdata, last_wdata, last_maddr;
  logic      last_err;
  int        last_lat;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic setm(input logic [31:0] addr, input logic [31:0] v);
    mem[addr[11:2]] = v;
  endtask

  task automatic model(input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input int d);
    logic [31:0] m, mask, v;
    int lane, t;
    bit tmo;
    lane = int'(addr[1:0]);
    m = mem[addr[11:2]];
    exp_maddr = {addr[31:2], 2'b00};
    exp_rdata = 0; exp_wdata = 0;
    exp_rd = 0; exp_wr = 0; exp_strobe = 0; exp_lat = 1;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && lane != 0);
    if (exp_err) return;
    tmo = (d < 0) || (d >= TO);
    t = tmo ? TO : d + 1;
    if (!we || size != 2'd2) begin
      exp_strobe += t; exp_lat += t;
      if (tmo) begin exp_err = 1; return; end
      exp_rd = 1;
    end
    if (!we) begin
      v = m >> (8 * lane);
      if (size == 2'd0) begin
        v &= 32'hFF;
        if (!uns && v[7]) v |= 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        v &= 32'hFFFF;
        if (!uns && v[15]) v |= 32'hFFFF_0000;
      end
      exp_rdata = v;
      return;
    end
    mask = (size == 2'd0) ? 32'hFF :
           (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << (8 * lane);
    exp_wdata = (m & ~mask) | ((wdata << (8 * lane)) & mask);
    exp_strobe += t; exp_lat += t;
    if (tmo) exp_err = 1;
    else     exp_wr = 1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      mem_ack = 0; wait_cnt = 0; prev_kind = 2'b00;
    end else begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc; n_rd = 0; n_wr = 0; n_strobe = 0;
      end
      if (mem_rd_en && mem_wr_en) check("both_strobes", 32'd1, 32'd0);
      if (mem_rd_en || mem_wr_en) begin
        n_strobe++;
        if (!exp_active) check("stray_strobe", 32'd1, 32'd0);
        else begin
          check("mem_addr", mem_addr, exp_maddr);
          last_maddr = mem_addr;
        end
      end
      if (resp_valid) begin
        if (!exp_active) check("stray_resp", 32'd1, 32'd0);
        else begin
          last_lat = cyc - acc_cyc;
          last_rdata = resp_rdata;
          last_err = resp_err;
          check("resp_rdata", resp_rdata, exp_rdata);
          check("resp_err", 32'(resp_err), 32'(exp_err));
          check("latency", 32'(last_lat), 32'(exp_lat));
          check("reads", 32'(n_rd), 32'(exp_rd));
          check("writes", 32'(n_wr), 32'(exp_wr));
          check("strobe_cycles", 32'(n_strobe), 32'(exp_strobe));
        end
        resp_seen++;
      end
      kind = {mem_rd_en, mem_wr_en};
      if (kind != prev_kind) wait_cnt = 0;
      prev_kind = kind;
      if (mem_rd_en || mem_wr_en) begin
        if (ack_delay >= 0 && wait_cnt >= ack_delay) begin
          mem_ack = 1;
          mem_rdata = mem[mem_addr[11:2]];
          if (mem_rd_en) n_rd++;
          if (mem_wr_en) begin
            n_wr++;
            last_wdata = mem_wdata;
            check("mem_wdata", mem_wdata, exp_wdata);
          end
        end else begin
          mem_ack = 0;
          mem_rdata = $urandom;
        end
        wait_cnt++;
      end else begin
        mem_ack = stray_ack;
        mem_rdata = $urandom;
      end
    end
  end

  // call just after a posedge; returns #1 after the accepting edge
  task automatic issue(input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input int d);
    ack_delay = d;
    model(we, size, uns, addr, wdata, d);
    exp_active = 1;
    resp_base = resp_seen;
    #1;
    check("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0;
    req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic wait_resp(input string name);
    for (int i = 0; i < 200 && resp_seen == resp_base; i++)
      @(posedge clk);
    if (resp_seen == resp_base) check(name, 32'd0, 32'd1);
    exp_active = 0;
  endtask

  task automatic run(input string name, input logic we,
                     input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int d);
    issue(we, size, uns, addr, wdata, d);
    wait_resp(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; req_valid = 0; req_we = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);

    setm(32'h100, 32'h80FF_1234);
    setm(32'h200, 32'hBEEF_0000);
    setm(32'h204, 32'h8001_7FFF);
    setm(32'h300, 32'h1122_3344);
    setm(32'h600, 32'hAABB_CCDD);
    setm(32'h700, 32'h5566_7788);

    run("lb", 0, 2'd0, 0, 32'h103, 32'h0, 0);
    check("lit_lb_rdata", last_rdata, 32'hFFFF_FF80);
    check("lit_lb_err", 32'(last_err), 32'd0);
    check("lit_lb_maddr", last_maddr, 32'h100);
    check("lit_lb_lat", 32'(last_lat), 32'd2);

    run("lhu", 0, 2'd1, 1, 32'h202, 32'h0, 0);
    check("lit_lhu_rdata", last_rdata, 32'h0000_BEEF);

    run("sb", 1, 2'd0, 0, 32'h301, 32'h5555_55AA, 0);
    check("lit_sb_wdata", last_wdata, 32'h1122_AA44);
    check("lit_sb_lat", 32'(last_lat), 32'd3);

    run("lw_mis", 0, 2'd2, 0, 32'h402, 32'h0, 0);
    check("lit_lw_mis_err", 32'(last_err), 32'd1);
    check("lit_lw_mis_lat", 32'(last_lat), 32'd1);

    run("sw_tmo", 1, 2'd2, 0, 32'h500, 32'h1234_5678, -1);
    check("lit_sw_tmo_err", 32'(last_err), 32'd1);
    check("lit_sw_tmo_lat", 32'(last_lat), 32'd17);

    stray_ack = 1;
    repeat (3) @(posedge clk);
    stray_ack = 0;
    run("lw_after_stray", 0, 2'd2, 0, 32'h100, 32'h0, 0);
    check("lit_lw_rdata", last_rdata, 32'h80FF_1234);

    run("lh_sign", 0, 2'd1, 0, 32'h206, 32'h0, 0);
    run("lbu_lane2", 0, 2'd0, 1, 32'h102, 32'h0, 0);
    run("lb_lane0", 0, 2'd0, 0, 32'h100, 32'h0, 0);
    run("lw_delay3", 0, 2'd2, 0, 32'h100, 32'h0, 3);
    run("sh_delay2", 1, 2'd1, 0, 32'h602, 32'h9999_1234, 2);
    check("lit_sh_wdata", last_wdata, 32'h1234_CCDD);
    run("sw_delay15", 1, 2'd2, 0, 32'h700, 32'h0BAD_F00D, 15);
    run("lb_delay16", 0, 2'd0, 0, 32'h103, 32'h0, 16);
    run("size_ill", 0, 2'd3, 0, 32'h100, 32'h0, 0);
    run("lh_mis", 0, 2'd1, 0, 32'h101, 32'h0, 0);
    run("sh_rmw_tmo", 1, 2'd1, 0, 32'h702, 32'hFFFF_0000, -1);
    run("sb_lane3", 1, 2'd0, 0, 32'h303, 32'h0000_0077, 1);

    issue(1, 2'd2, 0, 32'h7F0, 32'hCAFE_0001, -1);
    check("rst_mid_wr_before", 32'(mem_wr_en), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    exp_active = 0;
    rst = 0;
    #1;
    check("rst_mid_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mid_resp", 32'(resp_valid), 32'd0);
    check("rst_mid_maddr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (20) @(posedge clk);
    check("rst_mid_no_resp", 32'(resp_seen), 32'(resp_base));

    run("lw_after_rst", 0, 2'd2, 0, 32'h204, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
